// File: rtl/tohost_monitor_pkg.sv
// Shared definitions for the tohost/console monitor: mailbox addresses and FSM states.
package rv32i_pkg;

    localparam logic [31:0] TOHOST_ADDR_DEF  = 32'h8000_1000;
    localparam logic [31:0] CONSOLE_ADDR_DEF = 32'h8000_1004;

    typedef enum logic [1:0] {
        MON_RUN   = 2'd0,
        MON_DRAIN = 2'd1,
        MON_HALT  = 2'd2
    } monitor_state_t;

endpackage

// File: rtl/tohost_monitor_if.sv
// Data-memory write snoop port plus console byte stream of the tohost monitor.
interface tohost_monitor_if;

    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        con_valid;
    logic [7:0]  con_data;
    logic        con_ready;

    modport master (
        output mem_we, mem_addr, mem_wdata, mem_be, con_ready,
        input  con_valid, con_data
    );

    modport slave (
        input  mem_we, mem_addr, mem_wdata, mem_be, con_ready,
        output con_valid, con_data
    );

endinterface

// File: rtl/tohost_monitor_fifo.sv
// mon_fifo: 8-bit synchronous console FIFO; DEPTH must be a power of two >= 2.
module mon_fifo #(
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic [7:0] push_data_i,
    input  logic       pop_i,
    output logic       full_o,
    output logic       empty_o,
    output logic [7:0] head_o
);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok_s, pop_ok_s;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == (AW+1)'(0));
    assign head_o    = mem_q[rd_ptr_q];
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign pop_ok_s  = pop_i && !empty_o;
    assign push_ok_s = push_i && (!full_o || pop_ok_s);

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = push_ok_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= AW'(0);
            rd_ptr_q <= AW'(0);
            count_q  <= (AW+1)'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are meaningless outside the occupied window.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/tohost_monitor.sv
// Test-status monitor decoding tohost/console writes; watchdog under TOHOST_MONITOR_TIMEOUT_EN.
module tohost_monitor
    import rv32i_pkg::*;
#(
    parameter logic [31:0] TOHOST_ADDR    = TOHOST_ADDR_DEF,
    parameter logic [31:0] CONSOLE_ADDR   = CONSOLE_ADDR_DEF,
    parameter int          FIFO_DEPTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic               clk,
    input  logic               rst,
    tohost_monitor_if.slave    bus,
    output logic [15:0]        pass_cnt,
    output logic [15:0]        fail_cnt,
    output logic [30:0]        last_fail_id,
    output logic               done,
    output logic               timeout,
    output logic               overflow
);

    monitor_state_t state_q, state_d;
    logic [15:0] pass_cnt_q, pass_cnt_d;
    logic [15:0] fail_cnt_q, fail_cnt_d;
    logic [30:0] last_fail_id_q, last_fail_id_d;
    logic        done_q, done_d;
    logic        overflow_q, overflow_d;

    logic is_tohost_s, is_console_s, running_s;
    logic end_wr_s, pass_wr_s, fail_wr_s;
    logic push_s, pop_s, drop_s, timeout_hit_s;
    logic fifo_full_s, fifo_empty_s;
    logic unused_s;

    assign is_tohost_s  = bus.mem_we && (bus.mem_addr == TOHOST_ADDR);
    assign is_console_s = bus.mem_we && (bus.mem_addr == CONSOLE_ADDR);
    assign running_s    = (state_q == MON_RUN);
    assign end_wr_s     = is_tohost_s && running_s && (bus.mem_wdata == 32'd0);
    assign pass_wr_s    = is_tohost_s && running_s && (bus.mem_wdata == 32'd1);
    assign fail_wr_s    = is_tohost_s && running_s && bus.mem_wdata[0] && (bus.mem_wdata != 32'd1);
    assign push_s       = is_console_s && running_s && bus.mem_be[0];
    assign pop_s        = !fifo_empty_s && bus.con_ready;
    assign drop_s       = push_s && fifo_full_s && !pop_s;

    mon_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_s),
        .push_data_i (bus.mem_wdata[7:0]),
        .pop_i       (pop_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s),
        .head_o      (bus.con_data)
    );

    assign bus.con_valid = !fifo_empty_s;

`ifdef TOHOST_MONITOR_TIMEOUT_EN
    localparam logic [31:0] IDLE_LIMIT = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] idle_q, idle_d;
    logic        timeout_q, timeout_d;
    logic        qual_wr_s;

    // A qualifying write on the limit cycle clears the counter instead of firing.
    assign qual_wr_s     = is_tohost_s || is_console_s;
    assign timeout_hit_s = running_s && !qual_wr_s && (idle_q == IDLE_LIMIT);
    assign timeout       = timeout_q;
    assign unused_s      = ^bus.mem_be[3:1];

    // Idle counter next-state; frozen once the run has ended.
    always_comb begin
        if (!running_s) begin
            idle_d = idle_q;
        end else if (qual_wr_s) begin
            idle_d = 32'd0;
        end else begin
            idle_d = idle_q + 32'd1;
        end
        timeout_d = timeout_q || timeout_hit_s;
    end

    // Watchdog registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_q    <= 32'd0;
            timeout_q <= 1'b0;
        end else begin
            idle_q    <= idle_d;
            timeout_q <= timeout_d;
        end
    end
`else
    assign timeout_hit_s = 1'b0;
    assign timeout       = 1'b0;
    assign unused_s      = ^{bus.mem_be[3:1], 32'(TIMEOUT_CYCLES)};
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MON_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: HALT is left only through reset.
    always_comb begin
        case (state_q)
            MON_RUN:   state_d = (end_wr_s || timeout_hit_s) ? MON_DRAIN : MON_RUN;
            MON_DRAIN: state_d = fifo_empty_s ? MON_HALT : MON_DRAIN;
            MON_HALT:  state_d = MON_HALT;
            default:   state_d = MON_HALT;
        endcase
    end

    // Output next-values: saturating counters and sticky flags.
    always_comb begin
        if (pass_wr_s && (pass_cnt_q != 16'hFFFF)) begin
            pass_cnt_d = pass_cnt_q + 16'd1;
        end else begin
            pass_cnt_d = pass_cnt_q;
        end
        if (fail_wr_s && (fail_cnt_q != 16'hFFFF)) begin
            fail_cnt_d = fail_cnt_q + 16'd1;
        end else begin
            fail_cnt_d = fail_cnt_q;
        end
        if (fail_wr_s) begin
            last_fail_id_d = bus.mem_wdata[31:1];
        end else begin
            last_fail_id_d = last_fail_id_q;
        end
        done_d     = done_q || ((state_q == MON_DRAIN) && fifo_empty_s);
        overflow_d = overflow_q || drop_s;
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_cnt_q     <= 16'd0;
            fail_cnt_q     <= 16'd0;
            last_fail_id_q <= 31'd0;
            done_q         <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            pass_cnt_q     <= pass_cnt_d;
            fail_cnt_q     <= fail_cnt_d;
            last_fail_id_q <= last_fail_id_d;
            done_q         <= done_d;
            overflow_q     <= overflow_d;
        end
    end

    assign pass_cnt     = pass_cnt_q;
    assign fail_cnt     = fail_cnt_q;
    assign last_fail_id = last_fail_id_q;
    assign done         = done_q;
    assign overflow     = overflow_q;

endmodule
